// File: rtl/aes_inv_key_sched_if.sv
// Load/round-key handshake bundle between a key source and the inverse key scheduler.
interface aes_inv_key_sched_if;
    logic         ld;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         done;

    modport master (
        output ld, key, rk_ready,
        input  busy, rk_valid, rk, rk_idx, done
    );

    modport slave (
        input  ld, key, rk_ready,
        output busy, rk_valid, rk, rk_idx, done
    );
endinterface

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key schedule: expands the cipher key forward to round 10, then
// walks back to round 0 one key per handshake. Includes the combinational S-box.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), built from a^2..a^128.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] b;

    always_comb begin
        b = gf_inv(a);
        s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
endmodule

module aes_inv_key_sched (
    input logic              clk,
    input logic              rst,
    aes_inv_key_sched_if.slave ks
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] wk;
    logic [127:0] wk_nxt;
    logic [3:0]   cnt;
    logic [3:0]   cnt_nxt;
    logic         done_r;
    logic         done_nxt;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  w1_inv, w2_inv, w3_inv;
    logic [31:0]  sbox_in;
    logic [31:0]  sub_word;
    logic [3:0]   rc_round;
    logic [31:0]  rc_word;
    logic [127:0] fwd_key;
    logic [127:0] rev_key;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  r0;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    assign w0 = wk[127:96];
    assign w1 = wk[95:64];
    assign w2 = wk[63:32];
    assign w3 = wk[31:0];

    // Undoing the chained XORs recovers the previous round's w1..w3 first; the
    // recovered w3 is what the S-box must see to rebuild w0.
    assign w3_inv = w3 ^ w2;
    assign w2_inv = w2 ^ w1;
    assign w1_inv = w1 ^ w0;

    // One S-box bank serves both directions since FWD and REV never overlap.
    assign sbox_in  = (state == REV) ? rot_word(w3_inv) : rot_word(w3);
    assign rc_round = (state == REV) ? cnt : cnt + 4'd1;
    assign rc_word  = {rcon(rc_round), 24'h000000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .a (sbox_in[8*gi +: 8]),
                .s (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    assign f0      = w0 ^ sub_word ^ rc_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign r0      = w0 ^ sub_word ^ rc_word;
    assign rev_key = {r0, w1_inv, w2_inv, w3_inv};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wk     <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            wk     <= wk_nxt;
            cnt    <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wk_nxt      = wk;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        ks.busy     = (state != IDLE);
        ks.rk_valid = 1'b0;
        case (state)
            IDLE: begin
                if (ks.ld) begin
                    wk_nxt    = ks.key;
                    cnt_nxt   = 4'd0;
                    state_nxt = FWD;
                end
            end
            FWD: begin
                wk_nxt  = fwd_key;
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd9) state_nxt = REV;
            end
            REV: begin
                ks.rk_valid = 1'b1;
                if (ks.rk_ready) begin
                    if (cnt == 4'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        wk_nxt  = rev_key;
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ks.rk     = wk;
    assign ks.rk_idx = cnt;
    assign ks.done   = done_r;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 style forward expansion model with a
// cycle-level protocol tracker, randomized handshakes and interrupted loads.
module tb_aes_inv_key_sched;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

    localparam logic [127:0] SBOX_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [7:0] RCON [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic checking;

    aes_inv_key_sched_if ifc ();

    aes_inv_key_sched dut (
        .clk (clk),
        .rst (rst_n),
        .ks  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROW[x[7:4]];
        return row[127 - 8*int'(x[3:0]) -: 8];
    endfunction

    // Standard word-by-word key expansion; round r is words 4r..4r+3.
    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {RCON[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Protocol model: phase 0 idle, 1 expanding, 2 delivering.
    int           m_phase;
    int           m_cnt;
    int           m_idx;
    logic         m_done;
    logic [127:0] m_key;
    logic         stall_prev;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    int           hs_q [$];
    logic [127:0] cap_rk [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase    <= 0;
            m_cnt      <= 0;
            m_idx      <= 0;
            m_done     <= 1'b0;
            stall_prev <= 1'b0;
        end else begin
            m_done     <= 1'b0;
            stall_prev <= ifc.rk_valid && !ifc.rk_ready;
            prev_rk    <= ifc.rk;
            prev_idx   <= ifc.rk_idx;
            if (ifc.rk_valid && ifc.rk_ready) begin
                hs_q.push_back(int'(ifc.rk_idx));
                cap_rk[ifc.rk_idx] <= ifc.rk;
            end
            case (m_phase)
                0: if (ifc.ld) begin
                    m_key   <= ifc.key;
                    m_phase <= 1;
                    m_cnt   <= 0;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 9) begin
                        m_phase <= 2;
                        m_idx   <= 10;
                    end
                end
                default: if (ifc.rk_ready) begin
                    if (m_idx == 0) begin
                        m_phase <= 0;
                        m_done  <= 1'b1;
                    end else begin
                        m_idx <= m_idx - 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("busy", 128'(ifc.busy), 128'(m_phase != 0));
            check("rk_valid", 128'(ifc.rk_valid), 128'(m_phase == 2));
            check("done", 128'(ifc.done), 128'(m_done));
            if (m_phase == 2) begin
                check("rk", ifc.rk, round_key(m_key, m_idx));
                check("rk_idx", 128'(ifc.rk_idx), 128'(m_idx));
            end
            if (stall_prev && ifc.rk_valid) begin
                check("stall_rk", ifc.rk, prev_rk);
                check("stall_idx", 128'(ifc.rk_idx), 128'(prev_idx));
            end
        end
    end

    task automatic do_load(input logic [127:0] k);
        @(negedge clk);
        ifc.ld  = 1'b1;
        ifc.key = k;
        @(negedge clk);
        ifc.ld  = 1'b0;
        ifc.key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // mode 0: ready held high; 1: 5-cycle stall at round 10 then random ready;
    // 2: random ready plus stray loads during FWD, REV and the final handshake.
    task automatic run_seq(input logic [127:0] k, input int mode);
        int  cyc;
        int  lat;
        int  stall;
        logic finished;
        hs_q.delete();
        do_load(k);
        cyc      = 1;
        lat      = -1;
        stall    = 0;
        finished = 1'b0;
        ifc.rk_ready = (mode == 0);
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ifc.done) begin
                finished = 1'b1;
            end else begin
                if (ifc.rk_valid && lat < 0) lat = cyc;
                ifc.ld = 1'b0;
                case (mode)
                    0: ifc.rk_ready = 1'b1;
                    1: begin
                        if (ifc.rk_valid && ifc.rk_idx == 4'd10 && stall < 5) begin
                            ifc.rk_ready = 1'b0;
                            stall++;
                        end else begin
                            ifc.rk_ready = $urandom_range(0, 1) == 1;
                        end
                    end
                    default: begin
                        ifc.rk_ready = $urandom_range(0, 1) == 1;
                        if (cyc == 4 || (ifc.rk_valid && $urandom_range(0, 2) == 0)) ifc.ld = 1'b1;
                        if (ifc.rk_valid && ifc.rk_idx == 4'd0) begin
                            ifc.rk_ready = 1'b1;
                            ifc.ld       = 1'b1;
                        end
                        ifc.key = {$urandom, $urandom, $urandom, $urandom};
                    end
                endcase
            end
        end
        ifc.ld       = 1'b0;
        ifc.rk_ready = 1'b0;
        if (!finished) check("seq_timeout", 128'(cyc), 128'(0));
        check("ld_to_valid_cycles", 128'(lat), 128'(11));
        check("hs_count", 128'(hs_q.size()), 128'(11));
        for (int i = 0; i < hs_q.size() && i < 11; i++)
            check("hs_order", 128'(hs_q[i]), 128'(10 - i));
        @(negedge clk);
        check("done_one_cycle", 128'(ifc.done), 128'(0));
        check("idle_after_done", 128'(ifc.busy), 128'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 128'(ifc.busy), 128'(0));
        check({tag, "_rk_valid"}, 128'(ifc.rk_valid), 128'(0));
        check({tag, "_done"}, 128'(ifc.done), 128'(0));
        check({tag, "_rk"}, ifc.rk, 128'(0));
        check({tag, "_rk_idx"}, 128'(ifc.rk_idx), 128'(0));
    endtask

    // mode 0: reset after 5 FWD cycles; mode 1: reset after 3 REV handshakes.
    task automatic reset_mid(input int mode);
        int guard;
        hs_q.delete();
        do_load({$urandom, $urandom, $urandom, $urandom});
        if (mode == 0) begin
            repeat (4) @(negedge clk);
        end else begin
            ifc.rk_ready = 1'b1;
            guard = 0;
            while (hs_q.size() < 3 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) check("rev_wait_timeout", 128'(guard), 128'(0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(mode == 0 ? "rst_fwd" : "rst_rev");
        @(negedge clk);
        ifc.rk_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        checking     = 1'b0;
        rst_n        = 1'b0;
        ifc.ld       = 1'b0;
        ifc.key      = '0;
        ifc.rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n    = 1'b1;
        checking = 1'b1;

        check("model_k1_r10", round_key(K1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_k1_r1", round_key(K1, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("model_k2_r10", round_key(K2, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

        run_seq(K1, 0);
        check("k1_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("k1_rk1", cap_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("k1_rk0", cap_rk[0], K1);

        run_seq(K2, 0);
        check("k2_rk10", cap_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("k2_rk0", cap_rk[0], K2);

        run_seq(K1, 1);
        run_seq(K1, 2);
        check("disturbed_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("disturbed_rk0", cap_rk[0], K1);

        for (int n = 0; n < 4; n++)
            run_seq({$urandom, $urandom, $urandom, $urandom}, 1 + (n % 2));

        reset_mid(0);
        run_seq(K1, 0);
        check("post_rst_fwd_rk0", cap_rk[0], K1);
        reset_mid(1);
        run_seq(K1, 0);
        check("post_rst_rev_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("post_rst_rev_rk0", cap_rk[0], K1);

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 The block SHALL have no parameters; key length is fixed at 128 bits and round count at 10.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ld  input  1  load strobe; sampled only in IDLE.
REQ-005 key  input  128  cipher key, word w0 = key[127:96]; sampled on the accepted ld cycle.
REQ-006 busy  output  1  high in any state other than IDLE.
REQ-007 rk_valid  output  1  round key on rk is valid.
REQ-008 rk_ready  input  1  consumer accepts rk this cycle.
REQ-009 rk  output  128  decryption round key, word order as key.
REQ-010 rk_idx  output  4  round number of rk, 10 down to 0.
REQ-011 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-012 The FSM SHALL have three states: IDLE, FWD and REV.
REQ-013 In IDLE with ld=1, the block SHALL register key into the working key register, clear the round counter to 0, and enter FWD next cycle.
REQ-014 In FWD, each cycle SHALL apply one forward expansion step using rcon of the round being produced:
- w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
- wi' = wi ^ w(i-1)' for i = 1..3
- the counter increments each step.
REQ-015 The rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-016 After exactly 10 FWD cycles, the FSM SHALL enter REV holding round key 10.
REQ-017 rk_valid SHALL first assert 11 cycles after the ld-accept edge, with rk_idx=10.
REQ-018 In REV, rk_valid SHALL be 1, rk SHALL be the working register and rk_idx SHALL be the counter.
REQ-019 rk and rk_idx SHALL hold stable while rk_valid=1 and rk_ready=0.
REQ-020 On each REV handshake (rk_valid & rk_ready) with rk_idx>0, the next cycle SHALL hold round key rk_idx-1, computed by the inverse step with rcon of round rk_idx:
- w3' = w3 ^ w2
- w2' = w2 ^ w1
- w1' = w1 ^ w0
- w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon,24'h0}
REQ-021 On a handshake with rk_idx=0, the FSM SHALL return to IDLE, and done SHALL pulse for one cycle in the first IDLE cycle.
REQ-022 rk_valid SHALL be 0 in IDLE and FWD.
REQ-023 SubWord SHALL use four instances of the codebase aes_sbox, shared between FWD and REV, since only one state is active at a time.
REQ-024 ld while busy=1 SHALL be ignored and SHALL NOT disturb the sequence.
REQ-025 ld in the same cycle as the final handshake SHALL be ignored; a new load is accepted only from IDLE.
REQ-026 rk_ready while rk_valid=0 SHALL have no effect.
REQ-027 Counter arithmetic SHALL be 4-bit unsigned; it never exceeds 10 nor decrements below 0.
REQ-028 Back-to-back handshakes (rk_ready held high) SHALL deliver all 11 keys on 11 consecutive cycles.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, busy=0, rk_valid=0, done=0, rk=0 and rk_idx=0, from any state including mid-FWD and mid-REV.
REQ-030 After rst deasserts, the block SHALL be idle, and the first ld SHALL behave as from power-up.

Verification
REQ-031 key=2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 -> rk_valid rises 11 cycles after ld with rk=d014f9a8_c9ee2589_e13f0cc8_b6630ca6, rk_idx=10; rk_idx=1 gives a0fafe17_88542cb1_23a33939_2a6c7605; rk_idx=0 returns the key; done pulses once.
REQ-032 key=00010203_04050607_08090a0b_0c0d0e0f -> rk_idx=10 gives 13111d7f_e3944a17_f307a78b_4d2b30c5; rk_idx=0 returns the key.
REQ-033 Hold rk_ready=0 for 5 cycles at rk_idx=10, then toggle randomly -> rk and rk_idx stable while stalled; 11 keys delivered in order 10..0 and none skipped.
REQ-034 Pulse ld with a different key during FWD and during REV -> output sequence identical to the uninterrupted first-key sequence.
REQ-035 Assert rst at cycle 5 of FWD, and separately after 3 handshakes in REV -> all outputs 0 immediately; a subsequent ld produces the full correct sequence.
